// File: rtl/ppm16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ppm16_pkg
//  Description : Shared types and constants for the 16-ary PPM modulator:
//                FSM state encoding, chips per symbol, preamble symbols.
//  Revision    : 1.0 - initial release
// ============================================================================
package ppm16_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_HEADER   = 2'd2,
      ST_DATA     = 2'd3
   } ppm_state_t;

   localparam int         SYMBOL_CHIPS = 16;
   localparam logic [3:0] PRE_SYM_EVEN = 4'h0;
   localparam logic [3:0] PRE_SYM_ODD  = 4'hF;

   // Preamble alternates 0,F,0,F,... starting with symbol index 0
   function automatic logic [3:0] preamble_sym(input logic [7:0] k);
      return k[0] ? PRE_SYM_ODD : PRE_SYM_EVEN;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ppm16_chip_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ppm16_chip_gen
//  Description : Sample/chip position counters and the registered pulse
//                compare that produces the PPM chip-sample stream.
//                Optional macro PPM16_MOD_GUARD_EN adds a blank guard chip
//                after the 16 data chips of every symbol.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppm16_chip_gen
   import ppm16_pkg::*;
#(
   parameter int CHIP_BITS = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_start,      // restart position at chip 0 sample 0
   input  logic       i_run,        // current cycle belongs to a symbol
   input  logic       i_nxt_active, // next cycle belongs to a symbol
   input  logic [3:0] i_nxt_sym,    // symbol value of the next cycle
   input  logic       i_nxt_blank,  // next cycle's symbol carries no pulse
   output logic       o_sym_end,    // current cycle is the last of its symbol
   output logic       o_dout
);

   localparam int            SW            = (CHIP_BITS > 1) ? $clog2(CHIP_BITS) : 1;
   localparam logic [SW-1:0] C_LAST_SAMPLE = SW'(CHIP_BITS - 1);
`ifdef PPM16_MOD_GUARD_EN
   // Chip index 16 is the guard chip; it never matches a 4-bit symbol
   localparam logic [4:0]    C_LAST_CHIP   = 5'(SYMBOL_CHIPS);
`else
   localparam logic [4:0]    C_LAST_CHIP   = 5'(SYMBOL_CHIPS - 1);
`endif

   logic [SW-1:0] r_sample;
   logic [SW-1:0] w_nxt_sample;
   logic [4:0]    r_chip;
   logic [4:0]    w_nxt_chip;
   logic          r_dout;
   logic          w_chip_end;

   assign w_chip_end = (r_sample == C_LAST_SAMPLE);
   assign o_sym_end  = i_run && w_chip_end && (r_chip == C_LAST_CHIP);
   assign o_dout     = r_dout;

   // Next position: advance sample, then chip, wrapping at symbol end
   always_comb begin
      w_nxt_sample = '0;
      w_nxt_chip   = '0;
      if (i_run && !i_start) begin
         if (!w_chip_end) begin
            w_nxt_sample = r_sample + 1'b1;
            w_nxt_chip   = r_chip;
         end else if (r_chip != C_LAST_CHIP) begin
            w_nxt_chip   = r_chip + 5'd1;
         end
      end
   end

   // Position registers and registered pulse compare on the next position
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sample <= '0;
         r_chip   <= '0;
         r_dout   <= 1'b0;
      end else begin
         r_sample <= w_nxt_sample;
         r_chip   <= w_nxt_chip;
         r_dout   <= i_nxt_active && !i_nxt_blank && (w_nxt_chip == {1'b0, i_nxt_sym});
      end
   end

endmodule
`default_nettype wire

// File: rtl/ppm16_mod.sv
`default_nettype none
// ============================================================================
//  Module      : ppm16_mod
//  Description : 16-ary pulse-position modulator. Sends preamble, a two-
//                symbol length header and data_len data symbols pulled from
//                a valid/ready input. Missing data produces a blank symbol
//                and sets a sticky underflow flag.
//                Optional macro PPM16_MOD_GUARD_EN: one guard chip per symbol.
//  Revision    : 1.0 - initial release
// ============================================================================
module ppm16_mod
   import ppm16_pkg::*;
#(
   parameter int CHIP_BITS    = 4,
   parameter int PREAMBLE_LEN = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] data_len,
   input  logic [3:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       dout,
   output logic       busy,
   output logic       done,
   output logic       underflow
);

   localparam logic [7:0] C_LAST_PRE = 8'(PREAMBLE_LEN - 1);

   ppm_state_t r_state, w_state_nxt;
   logic [7:0] r_cnt, w_cnt_nxt;
   logic [7:0] r_len, w_len_nxt;
   logic [3:0] r_sym, w_sym_nxt;
   logic       r_blank, w_blank_nxt;
   logic       r_done, w_done_nxt;
   logic       r_underflow, w_underflow_nxt;
   logic       w_start;
   logic       w_sym_end;
   logic       w_last_pre;
   logic       w_last_data;
   logic [3:0] w_data_sym;
   logic       w_data_blank;

   assign w_last_pre   = (r_cnt == C_LAST_PRE);
   assign w_last_data  = (r_cnt == (r_len - 8'd1));
   assign w_data_sym   = din_valid ? din : 4'h0;
   assign w_data_blank = !din_valid;

   // Ready only in the final cycle of a symbol that is followed by data
   assign din_ready = w_sym_end &&
                      (((r_state == ST_HEADER) && (r_cnt == 8'd1) && (r_len != 8'd0)) ||
                       ((r_state == ST_DATA) && !w_last_data));

   assign busy      = (r_state != ST_IDLE);
   assign done      = r_done;
   assign underflow = r_underflow;

   // Next-state logic: sequence preamble, header and data symbols
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_len_nxt       = r_len;
      w_sym_nxt       = r_sym;
      w_blank_nxt     = r_blank;
      w_done_nxt      = 1'b0;
      w_underflow_nxt = r_underflow;
      w_start         = 1'b0;
      if (din_ready && !din_valid) begin
         w_underflow_nxt = 1'b1;
      end
      unique case (r_state)
         ST_IDLE: begin
            if (tx_start) begin
               w_start         = 1'b1;
               w_state_nxt     = ST_PREAMBLE;
               w_cnt_nxt       = 8'd0;
               w_len_nxt       = data_len;
               w_sym_nxt       = preamble_sym(8'd0);
               w_blank_nxt     = 1'b0;
               w_underflow_nxt = 1'b0;
            end
         end
         ST_PREAMBLE: begin
            if (w_sym_end) begin
               if (w_last_pre) begin
                  w_state_nxt = ST_HEADER;
                  w_cnt_nxt   = 8'd0;
                  w_sym_nxt   = r_len[7:4];
               end else begin
                  w_cnt_nxt   = r_cnt + 8'd1;
                  w_sym_nxt   = preamble_sym(r_cnt + 8'd1);
               end
            end
         end
         ST_HEADER: begin
            if (w_sym_end) begin
               if (r_cnt == 8'd0) begin
                  w_cnt_nxt   = 8'd1;
                  w_sym_nxt   = r_len[3:0];
               end else if (r_len == 8'd0) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = 8'd0;
                  w_sym_nxt   = 4'h0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = ST_DATA;
                  w_cnt_nxt   = 8'd0;
                  w_sym_nxt   = w_data_sym;
                  w_blank_nxt = w_data_blank;
               end
            end
         end
         ST_DATA: begin
            if (w_sym_end) begin
               if (w_last_data) begin
                  w_state_nxt = ST_IDLE;
                  w_cnt_nxt   = 8'd0;
                  w_sym_nxt   = 4'h0;
                  w_blank_nxt = 1'b0;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_cnt_nxt   = r_cnt + 8'd1;
                  w_sym_nxt   = w_data_sym;
                  w_blank_nxt = w_data_blank;
               end
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counters and status flags
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= 8'd0;
         r_len       <= 8'd0;
         r_sym       <= 4'h0;
         r_blank     <= 1'b0;
         r_done      <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_len       <= w_len_nxt;
         r_sym       <= w_sym_nxt;
         r_blank     <= w_blank_nxt;
         r_done      <= w_done_nxt;
         r_underflow <= w_underflow_nxt;
      end
   end

   ppm16_chip_gen #(
      .CHIP_BITS (CHIP_BITS)
   ) u_chip_gen (
      .clk          (clk),
      .reset        (reset),
      .i_start      (w_start),
      .i_run        (busy),
      .i_nxt_active (w_state_nxt != ST_IDLE),
      .i_nxt_sym    (w_sym_nxt),
      .i_nxt_blank  (w_blank_nxt),
      .o_sym_end    (w_sym_end),
      .o_dout       (dout)
   );

endmodule
`default_nettype wire

// File: tb/tb_ppm16_mod.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ppm16_mod
//  Description : Scoreboard bench for ppm16_mod. Stimulus pushes expected
//                symbols and packet records; a monitor decodes dout per
//                symbol window and compares at each window and at done.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ppm16_mod;

   localparam int CB  = 4;
   localparam int PRE = 8;
`ifdef PPM16_MOD_GUARD_EN
   localparam int SYM_CH = 17;
`else
   localparam int SYM_CH = 16;
`endif
   localparam int WIN = SYM_CH * CB;
   localparam int BLANK = 16;

   typedef struct packed {
      logic [3:0] val;
      logic       vld;
   } din_item_t;

   typedef struct {
      int cycles;
      bit uf;
      int rdy;
   } pkt_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       tx_start = 1'b0;
   logic [7:0] data_len = 8'd0;
   logic [3:0] din = 4'h0;
   logic       din_valid = 1'b0;
   logic       din_ready, dout, busy, done, underflow;

   int        sym_q[$];
   pkt_t      pkt_q[$];
   din_item_t data_q[$];
   int        n_vec = 0;
   int        n_fail = 0;

   always #5 clk = ~clk;

   ppm16_mod #(.CHIP_BITS(CB), .PREAMBLE_LEN(PRE)) dut (
      .clk       (clk),
      .reset     (reset),
      .tx_start  (tx_start),
      .data_len  (data_len),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (din_ready),
      .dout      (dout),
      .busy      (busy),
      .done      (done),
      .underflow (underflow)
   );

   function automatic logic [WIN-1:0] sym_wave(input int code);
      logic [WIN-1:0] w;
      w = '0;
      if (code < 16)
         for (int i = 0; i < CB; i++) w[code*CB + i] = 1'b1;
      return w;
   endfunction

   // Hand lengths are for 16-chip symbols; guard build scales by 17/16
   function automatic int exp_len(input int n16);
      return n16 * SYM_CH / 16;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_vec++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   // Data driver: present head item; a ready slot consumes it (valid or not)
   initial begin
      forever begin
         @(negedge clk);
         if (data_q.size() > 0) begin
            din       = data_q[0].val;
            din_valid = data_q[0].vld;
            if (din_ready) void'(data_q.pop_front());
         end else begin
            din       = 4'h0;
            din_valid = 1'b0;
         end
      end
   end

   // Monitor: per-symbol waveform compare and per-packet compare at done
   initial begin
      int pos, cyc, rdy, sidx, exp_code;
      logic [WIN-1:0] got_bits;
      pkt_t p;
      pos = 0; cyc = 0; rdy = 0; sidx = 0; exp_code = BLANK; got_bits = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pos = 0; cyc = 0; rdy = 0;
         end else begin
            if (din_ready) rdy++;
            if (busy) begin
               if (pos == 0) begin
                  got_bits = '0;
                  if (sym_q.size() == 0) begin
                     n_vec++; n_fail++;
                     $display("FAIL sym_unexpected: got a symbol, expected none");
                     exp_code = BLANK;
                  end else begin
                     exp_code = sym_q.pop_front();
                  end
               end
               got_bits[pos] = dout;
               pos++; cyc++;
               if (pos == WIN) begin
                  n_vec++;
                  if (got_bits != sym_wave(exp_code)) begin
                     n_fail++;
                     $display("FAIL sym%0d: got wave %h expected code %0d wave %h",
                              sidx, got_bits, exp_code, sym_wave(exp_code));
                  end
                  sidx++;
                  pos = 0;
               end
            end else begin
               check("idle_dout", int'(dout), 0);
            end
            if (done) begin
               if (pkt_q.size() == 0) begin
                  n_vec++; n_fail++;
                  $display("FAIL done_unexpected: got done, expected none");
               end else begin
                  p = pkt_q.pop_front();
                  check("pkt_len", cyc, p.cycles);
                  check("pkt_underflow", int'(underflow), int'(p.uf));
                  check("pkt_ready_cnt", rdy, p.rdy);
                  check("pkt_partial_sym", pos, 0);
               end
               cyc = 0; rdy = 0; pos = 0;
            end
         end
      end
   end

   // Push expectations and pulse tx_start; called at a negedge
   task automatic send(input logic [7:0] len, input logic [3:0] v0, input logic [3:0] v1,
                       input logic [3:0] v2, input logic [2:0] vld, input int cycles16,
                       input bit uf);
      logic [3:0] v [3];
      pkt_t p;
      v[0] = v0; v[1] = v1; v[2] = v2;
      for (int k = 0; k < PRE; k++) sym_q.push_back((k % 2 == 1) ? 15 : 0);
      sym_q.push_back(int'(len[7:4]));
      sym_q.push_back(int'(len[3:0]));
      for (int i = 0; i < int'(len); i++) begin
         sym_q.push_back(vld[i] ? int'(v[i]) : BLANK);
         data_q.push_back('{val: v[i], vld: vld[i]});
      end
      p.cycles = exp_len(cycles16); p.uf = uf; p.rdy = int'(len);
      pkt_q.push_back(p);
      tx_start = 1'b1;
      data_len = len;
      @(negedge clk);
      tx_start = 1'b0;
      data_len = 8'hFF;
   endtask

   task automatic wait_done(input string name);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 4000 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (!seen) begin
         n_vec++; n_fail++;
         $display("FAIL %s_timeout: got no done, expected done", name);
      end
   endtask

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      check("rst_dout", int'(dout), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_ready", int'(din_ready), 0);
      check("rst_underflow", int'(underflow), 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // data_len=3, 5,A,0 valid: 13 symbols = 832 cycles
      send(8'd3, 4'h5, 4'hA, 4'h0, 3'b111, 832, 1'b0);
      wait_done("pkt_a");
      repeat (2) @(negedge clk);

      // data_len=0: preamble + header 0,0 only, 640 cycles, no ready
      send(8'd0, 4'h0, 4'h0, 4'h0, 3'b000, 640, 1'b0);
      wait_done("pkt_b");
      repeat (2) @(negedge clk);

      // data_len=2, second slot missing: blank symbol, underflow, 768 cycles
      send(8'd2, 4'h7, 4'h3, 4'h0, 3'b001, 768, 1'b1);
      wait_done("pkt_c");
      repeat (3) @(negedge clk);
      check("underflow_sticky", int'(underflow), 1);

      // data_len=1 with a mid-packet retrigger and length change (ignored)
      send(8'd1, 4'h9, 4'h0, 4'h0, 3'b001, 704, 1'b0);
      check("underflow_cleared", int'(underflow), 0);
      repeat (100) @(negedge clk);
      tx_start = 1'b1;
      data_len = 8'd9;
      @(negedge clk);
      tx_start = 1'b0;
      wait_done("pkt_d");

      // tx_start coincident with done: next packet with no gap
      send(8'd2, 4'h3, 4'hC, 4'h0, 3'b011, 768, 1'b0);
      check("no_gap_busy", int'(busy), 1);
      wait_done("pkt_e");
      repeat (2) @(negedge clk);

      // Reset mid-packet at cycle 300: outputs drop immediately, no done
      send(8'd3, 4'h1, 4'h2, 4'h4, 3'b111, 832, 1'b0);
      repeat (299) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("mid_rst_dout", int'(dout), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_ready", int'(din_ready), 0);
      check("mid_rst_done", int'(done), 0);
      sym_q.delete();
      pkt_q.delete();
      data_q.delete();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      check("post_rst_idle", int'(busy), 0);
      check("post_rst_done", int'(done), 0);

      // Fresh packet after reset starts from preamble symbol 0
      send(8'd1, 4'hF, 4'h0, 4'h0, 3'b001, 704, 1'b0);
      wait_done("pkt_f");
      repeat (3) @(negedge clk);

      check("sym_q_empty", sym_q.size(), 0);
      check("pkt_q_empty", pkt_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ppm16_mod.md
PPM16_MOD -- requirements
Module: ppm16_mod

Interface
REQ-001 SHALL have parameter CHIP_BITS, default 4, clock cycles per chip.
REQ-002 SHALL have parameter PREAMBLE_LEN, default 8, number of preamble symbols.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port tx_start, input, 1, one-cycle request to begin a packet.
REQ-006 SHALL have port data_len, input, 8, number of data symbols, sampled with tx_start.
REQ-007 SHALL have port din, input, 4, data symbol value.
REQ-008 SHALL have port din_valid, input, 1, din holds a symbol.
REQ-009 SHALL have port din_ready, output, 1, modulator takes din this cycle.
REQ-010 SHALL have port dout, output, 1, registered chip-sample stream.
REQ-011 SHALL have port busy, output, 1, packet in progress.
REQ-012 SHALL have port done, output, 1, one-cycle end-of-packet pulse.
REQ-013 SHALL have port underflow, output, 1, sticky missing-data flag.

Function
REQ-014 SHALL encode each symbol s as 16 chips of CHIP_BITS cycles: dout high for all CHIP_BITS cycles of chip s, low otherwise.
REQ-015 SHALL implement states IDLE, PREAMBLE, HEADER, DATA; IDLE->PREAMBLE on tx_start; PREAMBLE->HEADER after PREAMBLE_LEN symbols; HEADER->DATA after 2 symbols, or HEADER->IDLE if latched length is 0; DATA->IDLE after data_len symbols.
REQ-016 SHALL emit preamble symbol k as 4'h0 for even k, 4'hF for odd k.
REQ-017 SHALL emit header as data_len[7:4] then data_len[3:0].
REQ-018 SHALL, on the edge sampling tx_start=1 in IDLE, latch data_len, clear underflow, set busy, and present chip 0 sample 0 of preamble symbol 0 on dout after that same edge.
REQ-019 SHALL ignore tx_start when not IDLE; data_len changes mid-packet have no effect.
REQ-020 SHALL drive din_ready high (combinationally from state/counters only, never from din_valid) exactly during the last cycle of any symbol whose successor is a DATA symbol; transfer occurs when din_valid and din_ready are both high.
REQ-021 SHALL, if din_valid is low while din_ready is high, emit an all-zero (blank) symbol in that slot, set underflow, and still count the slot.
REQ-022 SHALL present symbols back to back with no idle cycles; packet length = (PREAMBLE_LEN+2+data_len)*16*CHIP_BITS cycles.
REQ-023 SHALL drop busy and pulse done for one cycle on the cycle after the last sample of the last symbol; dout SHALL be 0 in IDLE.
REQ-024 SHALL accept tx_start on the same cycle done is high.

Reset
REQ-025 SHALL, on reset assertion at any time including mid-packet, immediately force IDLE, dout=0, busy=0, done=0, din_ready=0, underflow=0, all counters 0.
REQ-026 SHALL hold these values until the first rising clk edge after reset deassertion, and require a new tx_start afterwards.

Configuration
REQ-027 SHALL, with macro PPM16_MOD_GUARD_EN defined, append one guard chip (CHIP_BITS cycles, dout=0) after every symbol (17 chips per symbol), with din_ready moved to the guard's last cycle.
REQ-028 SHALL, without PPM16_MOD_GUARD_EN, use exactly 16 chips per symbol and contain no guard logic.

Structure
REQ-029 SHALL take state enum, SYMBOL_CHIPS=16, and preamble symbol constants from shared package ppm16_pkg.
REQ-030 SHALL place the sample/chip counters and pulse compare in sub-module ppm16_chip_gen, with the FSM and handshake in ppm16_mod.

Verification
REQ-031 CHIP_BITS=4, data_len=3, din 4'h5,4'hA,4'h0 always valid -> busy 832 cycles; header 0x0,0x3; data symbols pulse at cycle offsets 20-23, 40-43, 0-3; done once; underflow=0.
REQ-032 data_len=0 -> preamble and header 0x0,0x0 only, 640 busy cycles, din_ready never high.
REQ-033 data_len=2, din_valid low for second data slot -> second data symbol all zero, underflow=1 until next tx_start, length unchanged at 768 cycles.
REQ-034 reset pulsed at cycle 300 of a packet -> dout, busy, din_ready 0 immediately; no done; next tx_start gives full packet from preamble symbol 0.
REQ-035 tx_start re-pulsed mid-packet and data_len changed -> ignored; tx_start coincident with done -> next packet starts with no gap.
REQ-036 PPM16_MOD_GUARD_EN defined, data_len=3 -> 884 busy cycles, each symbol followed by 4 low cycles.
